// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle datapath: FSM states, IR field
// positions, ALU operation codes and default widths.
package mc_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REGS   = 15;

  localparam int RN_HI = 19;
  localparam int RN_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 12;
  localparam int RM_HI = 3;
  localparam int RM_LO = 0;

  localparam logic [3:0] PC_REG = 4'd15;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_EOR = 4'd4;
  localparam logic [3:0] ALU_MOV = 4'd5;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;
endpackage

// File: rtl/mc_ctrl_fsm.sv
// Instruction sequencer: state register plus next-state logic, producing the
// datapath register enables and the memory request strobes.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic imem_ack_i,
  input  logic dmem_ack_i,
  input  logic cond_ex_i,
  input  logic is_mem_i,
  input  logic mem_write_i,
  input  logic pc_src_i,
  input  logic reg_write_i,
  output logic ir_en_o,
  output logic ab_en_o,
  output logic alu_en_o,
  output logic mdr_en_o,
  output logic pc_en_o,
  output logic pc_load_o,
  output logic rf_we_o,
  output logic imem_req_o,
  output logic dmem_req_o,
  output logic dmem_we_o,
  output logic done_o
);
  state_t state_q, state_d;
  logic   run_q;

  // run_q holds off the first fetch until a clock edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d    = state_q;
    ir_en_o    = 1'b0;
    ab_en_o    = 1'b0;
    alu_en_o   = 1'b0;
    mdr_en_o   = 1'b0;
    pc_en_o    = 1'b0;
    pc_load_o  = 1'b0;
    rf_we_o    = 1'b0;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_o = run_q;
        if (run_q && imem_ack_i) begin
          ir_en_o = 1'b1;
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        ab_en_o = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        alu_en_o = 1'b1;
        if (!cond_ex_i) begin
          pc_en_o = 1'b1;
          done_o  = 1'b1;
          state_d = FETCH;
        end else if (is_mem_i) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = mem_write_i;
        if (dmem_ack_i && mem_write_i) begin
          pc_en_o = 1'b1;
          done_o  = 1'b1;
          state_d = FETCH;
        end else if (dmem_ack_i) begin
          mdr_en_o = 1'b1;
          state_d  = WB;
        end else begin
          state_d = MEM;
        end
      end
      WB: begin
        pc_en_o = 1'b1;
        done_o  = 1'b1;
        state_d = FETCH;
        // R15 is the PC, so a branch never writes the register file
        if (pc_src_i) begin
          pc_load_o = 1'b1;
        end else begin
          rf_we_o = reg_write_i;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end
endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle ARM-style datapath: register file, immediate extender, ALU and the
// IR/A/B/Imm/ALUOut/MDR/PC registers, sequenced by mc_ctrl_fsm.
module multicycle_datapath
  import mc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  input  logic [3:0]        alu_control,
  input  logic              alu_src,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic              pc_src,
  input  logic              is_mem,
  input  logic              cond_ex,
  input  logic [1:0]        imm_src,
  input  logic [1:0]        reg_src,
  output logic [3:0]        alu_flags,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              instr_done
);
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q, alu_out_q, mdr_q;
  logic [3:0]        flags_q;
  logic [DATA_W-1:0] rf_q [0:NUM_REGS-1];

  logic              ir_en_s, ab_en_s, alu_en_s, mdr_en_s, pc_en_s, pc_load_s, rf_we_s;
  logic [3:0]        ra1_s, ra2_s;
  logic [DATA_W-1:0] rd1_s, rd2_s, r15_s, imm_ext_s;
  logic [DATA_W-1:0] src_b_s, opb_s, alu_res_s, result_s;
  logic [DATA_W:0]   sum_s;
  logic              sub_s, carry_s, ovf_s;
  logic [3:0]        nzcv_s;
  logic [ADDR_W-1:0] pc_plus1_s;

  mc_ctrl_fsm u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .imem_ack_i  (imem_ack),
    .dmem_ack_i  (dmem_ack),
    .cond_ex_i   (cond_ex),
    .is_mem_i    (is_mem),
    .mem_write_i (mem_write),
    .pc_src_i    (pc_src),
    .reg_write_i (reg_write),
    .ir_en_o     (ir_en_s),
    .ab_en_o     (ab_en_s),
    .alu_en_o    (alu_en_s),
    .mdr_en_o    (mdr_en_s),
    .pc_en_o     (pc_en_s),
    .pc_load_o   (pc_load_s),
    .rf_we_o     (rf_we_s),
    .imem_req_o  (imem_req),
    .dmem_req_o  (dmem_req),
    .dmem_we_o   (dmem_we),
    .done_o      (instr_done)
  );

  // Register-file read ports; R15 reads as the word-address analogue of PC+8
  always_comb begin
    pc_plus1_s = pc_q + ADDR_W'(1'b1);
    r15_s      = DATA_W'(pc_q + ADDR_W'(2'd2));
    ra1_s      = reg_src[0] ? PC_REG : ir_q[RN_HI:RN_LO];
    ra2_s      = reg_src[1] ? ir_q[RD_HI:RD_LO] : ir_q[RM_HI:RM_LO];
    rd1_s      = (ra1_s == PC_REG) ? r15_s : rf_q[ra1_s];
    rd2_s      = (ra2_s == PC_REG) ? r15_s : rf_q[ra2_s];
  end

  // Immediate extender: 8/12-bit zero-extended or 24-bit sign-extended offset
  always_comb begin
    imm_ext_s = {DATA_W{1'b0}};
    case (imm_src)
      2'd0:    imm_ext_s = DATA_W'(ir_q[7:0]);
      2'd1:    imm_ext_s = DATA_W'(ir_q[11:0]);
      2'd2:    imm_ext_s = DATA_W'($signed(ir_q[23:0]));
      default: imm_ext_s = {DATA_W{1'b0}};
    endcase
  end

  // ALU with NZCV; subtraction is a + ~b + 1 so carry means "no borrow"
  always_comb begin
    sub_s     = (alu_control == ALU_SUB);
    src_b_s   = alu_src ? imm_q : b_q;
    opb_s     = sub_s ? ~src_b_s : src_b_s;
    sum_s     = {1'b0, a_q} + {1'b0, opb_s} + {{DATA_W{1'b0}}, sub_s};
    alu_res_s = {DATA_W{1'b0}};
    carry_s   = 1'b0;
    ovf_s     = 1'b0;
    case (alu_control)
      ALU_ADD, ALU_SUB: begin
        alu_res_s = sum_s[DATA_W-1:0];
        carry_s   = sum_s[DATA_W];
        ovf_s     = (a_q[DATA_W-1] == opb_s[DATA_W-1]) && (sum_s[DATA_W-1] != a_q[DATA_W-1]);
      end
      ALU_AND: alu_res_s = a_q & src_b_s;
      ALU_ORR: alu_res_s = a_q | src_b_s;
      ALU_EOR: alu_res_s = a_q ^ src_b_s;
      ALU_MOV: alu_res_s = src_b_s;
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
    nzcv_s   = {alu_res_s[DATA_W-1], (alu_res_s == {DATA_W{1'b0}}), carry_s, ovf_s};
    result_s = mem_to_reg ? mdr_q : alu_out_q;
  end

  // Datapath pipeline registers and PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= {ADDR_W{1'b0}};
      ir_q      <= 32'h0;
      a_q       <= {DATA_W{1'b0}};
      b_q       <= {DATA_W{1'b0}};
      imm_q     <= {DATA_W{1'b0}};
      alu_out_q <= {DATA_W{1'b0}};
      mdr_q     <= {DATA_W{1'b0}};
      flags_q   <= 4'h0;
    end else begin
      if (ir_en_s) ir_q <= imem_rdata;
      if (ab_en_s) begin
        a_q   <= rd1_s;
        b_q   <= rd2_s;
        imm_q <= imm_ext_s;
      end
      if (alu_en_s) begin
        alu_out_q <= alu_res_s;
        flags_q   <= nzcv_s;
      end
      if (mdr_en_s) mdr_q <= dmem_rdata;
      if (pc_en_s) pc_q <= pc_load_s ? result_s[ADDR_W-1:0] : pc_plus1_s;
    end
  end

  // General-purpose registers R0..R14
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= {DATA_W{1'b0}};
    end else if (rf_we_s && (ir_q[RD_HI:RD_LO] != PC_REG)) begin
      rf_q[ir_q[RD_HI:RD_LO]] <= result_s;
    end
  end

  assign imem_addr  = pc_q;
  assign instr      = ir_q;
  assign alu_flags  = flags_q;
  assign dmem_addr  = alu_out_q;
  assign dmem_wdata = b_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench: acts as decoder and wait-state memories, scoreboarding
// retirement latency, fetch addresses and data-memory transactions.
module tb_multicycle_datapath;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, instr_done;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata, instr, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  alu_control, alu_flags;
  logic        alu_src, mem_to_reg, reg_write, mem_write, pc_src, is_mem, cond_ex;
  logic [1:0]  imm_src, reg_src;

  multicycle_datapath #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .alu_control(alu_control),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_write(mem_write),
    .pc_src(pc_src), .is_mem(is_mem), .cond_ex(cond_ex), .imm_src(imm_src), .reg_src(reg_src),
    .alu_flags(alu_flags), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] aluc;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       reg_write, mem_to_reg, is_mem, mem_write, pc_src, cond_ex;
  } ctl_t;

  localparam ctl_t C_MOV  = '{ALU_MOV, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctl_t C_LDR  = '{ALU_ADD, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam ctl_t C_STR  = '{ALU_ADD, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctl_t C_SUB  = '{ALU_SUB, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctl_t C_SUBN = '{ALU_SUB, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t C_BR   = '{ALU_ADD, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctl_t C_BR15 = '{ALU_ADD, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  typedef struct {
    int          cycles;
    logic [12:0] faddr;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int          o_cyc, o_ireq;
  logic        o_astab, o_irstab, o_excl, o_sawd, o_dwe;
  logic [12:0] o_faddr;
  logic [31:0] o_daddr, o_dwdata;

  function automatic logic [31:0] mk(input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] imm);
    return {4'hE, 8'h28, rn, rd, imm};
  endfunction

  task automatic apply_ctl(input ctl_t c);
    alu_control = c.aluc;    alu_src = c.alu_src;       imm_src = c.imm_src;
    reg_src     = c.reg_src; reg_write = c.reg_write;   mem_to_reg = c.mem_to_reg;
    is_mem      = c.is_mem;  mem_write = c.mem_write;   pc_src = c.pc_src;
    cond_ex     = c.cond_ex;
  endtask

  // Called just after a negedge with the DUT in FETCH; returns at the negedge after retirement.
  task automatic exec_instr(input logic [31:0] iw, input ctl_t c, input int iwait, input int dwait,
                            input logic [31:0] rdata);
    logic [31:0] ir_before;
    int iw_cnt, dw_cnt;
    logic done;
    apply_ctl(c);
    ir_before = instr;
    o_cyc = 0; o_ireq = 0; iw_cnt = 0; dw_cnt = 0; done = 1'b0;
    o_astab = 1'b1; o_irstab = 1'b1; o_excl = 1'b1; o_sawd = 1'b0;
    o_faddr = 13'h0; o_dwe = 1'b0; o_daddr = 32'h0; o_dwdata = 32'h0;
    while (!done && o_cyc < 60) begin
      o_cyc++;
      if (imem_req && dmem_req) o_excl = 1'b0;
      if (imem_req) begin
        if (o_ireq == 0) o_faddr = imem_addr;
        else if (imem_addr !== o_faddr) o_astab = 1'b0;
        if (instr !== ir_before) o_irstab = 1'b0;
        o_ireq++;
        imem_ack   = (iw_cnt >= iwait);
        imem_rdata = imem_ack ? iw : 32'h0BAD_0BAD;
        iw_cnt++;
      end else begin
        imem_ack = 1'b0;
      end
      if (dmem_req) begin
        if (!o_sawd) begin
          o_sawd = 1'b1; o_dwe = dmem_we; o_daddr = dmem_addr; o_dwdata = dmem_wdata;
        end
        dmem_ack   = (dw_cnt >= dwait);
        dmem_rdata = dmem_ack ? rdata : 32'h0;
        dw_cnt++;
      end else begin
        dmem_ack = 1'b0;
      end
      #1;
      done = instr_done;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_imem_req: got %b expected 0", imem_req); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL rst_dmem_req: got %b expected 0", dmem_req); else n_pass++;
    n_checks++; if (instr_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", instr_done); else n_pass++;
    n_checks++; if (instr !== 32'h0) $display("FAIL rst_ir: got %h expected 0", instr); else n_pass++;
    n_checks++; if (alu_flags !== 4'h0) $display("FAIL rst_flags: got %h expected 0", alu_flags); else n_pass++;
    n_checks++; if (imem_addr !== 13'h0) $display("FAIL rst_pc: got %h expected 0", imem_addr); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1) $display("FAIL rst_first_req: got %b expected 1", imem_req); else n_pass++;
  endtask

  task automatic test_mov();
    exp_t e;
    exp_q.push_back('{4, 13'h0, 1'b0, 32'h0, 32'h0});
    exec_instr(mk(4'd0, 4'd1, 12'h005), C_MOV, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL mov_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL mov_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (imem_addr !== 13'h1) $display("FAIL mov_next_pc: got %h expected 1", imem_addr); else n_pass++;
    n_checks++; if (alu_flags !== 4'h0) $display("FAIL mov_flags: got %h expected 0", alu_flags); else n_pass++;
  endtask

  task automatic test_fetch_wait();
    exp_t e;
    exp_q.push_back('{7, 13'h1, 1'b0, 32'h0, 32'h0});
    exec_instr(mk(4'd0, 4'd2, 12'h040), C_MOV, 3, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL fw_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL fw_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (o_ireq !== 4) $display("FAIL fw_req_cycles: got %0d expected 4", o_ireq); else n_pass++;
    n_checks++; if (o_astab !== 1'b1) $display("FAIL fw_addr_stable: got %b expected 1", o_astab); else n_pass++;
    n_checks++; if (o_irstab !== 1'b1) $display("FAIL fw_ir_held: got %b expected 1", o_irstab); else n_pass++;
    n_checks++; if (instr !== mk(4'd0, 4'd2, 12'h040)) $display("FAIL fw_ir_loaded: got %h expected %h", instr, mk(4'd0, 4'd2, 12'h040)); else n_pass++;
  endtask

  task automatic test_load();
    exp_t e;
    exp_q.push_back('{7, 13'h2, 1'b0, 32'h44, 32'h0});
    exp_q.push_back('{4, 13'h3, 1'b1, 32'h40, 32'hCAFE_F00D});
    exec_instr(mk(4'd2, 4'd3, 12'h004), C_LDR, 0, 2, 32'hCAFE_F00D);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL ldr_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL ldr_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (o_sawd !== 1'b1) $display("FAIL ldr_dreq: got %b expected 1", o_sawd); else n_pass++;
    n_checks++; if (o_dwe !== e.dwe) $display("FAIL ldr_we: got %b expected %b", o_dwe, e.dwe); else n_pass++;
    n_checks++; if (o_daddr !== e.daddr) $display("FAIL ldr_addr: got %h expected %h", o_daddr, e.daddr); else n_pass++;
    exec_instr(mk(4'd2, 4'd3, 12'h000), C_STR, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL ldr_chk_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (o_dwdata !== e.dwdata) $display("FAIL ldr_r3_value: got %h expected %h", o_dwdata, e.dwdata); else n_pass++;
  endtask

  task automatic test_store();
    exp_t e;
    exp_q.push_back('{4, 13'h4, 1'b1, 32'h40, 32'h5});
    exec_instr(mk(4'd2, 4'd1, 12'h000), C_STR, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL str_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL str_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (o_dwe !== e.dwe) $display("FAIL str_we: got %b expected %b", o_dwe, e.dwe); else n_pass++;
    n_checks++; if (o_daddr !== e.daddr) $display("FAIL str_addr: got %h expected %h", o_daddr, e.daddr); else n_pass++;
    n_checks++; if (o_dwdata !== e.dwdata) $display("FAIL str_wdata: got %h expected %h", o_dwdata, e.dwdata); else n_pass++;
    n_checks++; if (o_excl !== 1'b1) $display("FAIL str_req_exclusive: got %b expected 1", o_excl); else n_pass++;
  endtask

  task automatic test_cond_fail();
    exp_t e;
    exp_q.push_back('{3, 13'h5, 1'b0, 32'h0, 32'h0});
    exp_q.push_back('{4, 13'h6, 1'b1, 32'h40, 32'h5});
    exec_instr(mk(4'd1, 4'd1, 12'h005), C_SUBN, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL cf_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (alu_flags !== 4'b0110) $display("FAIL cf_flags: got %b expected 0110", alu_flags); else n_pass++;
    n_checks++; if (imem_addr !== 13'h6) $display("FAIL cf_next_pc: got %h expected 6", imem_addr); else n_pass++;
    exec_instr(mk(4'd2, 4'd1, 12'h000), C_STR, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL cf_chk_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (o_dwdata !== e.dwdata) $display("FAIL cf_no_write: got %h expected %h", o_dwdata, e.dwdata); else n_pass++;
  endtask

  task automatic test_flags();
    exp_t e;
    exp_q.push_back('{4, 13'h7, 1'b0, 32'h0, 32'h0});
    exp_q.push_back('{4, 13'h8, 1'b1, 32'h40, 32'hFFFF_FFFF});
    exec_instr(mk(4'd2, 4'd4, 12'h041), C_SUB, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL sub_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (alu_flags !== 4'b1000) $display("FAIL sub_flags: got %b expected 1000", alu_flags); else n_pass++;
    exec_instr(mk(4'd2, 4'd4, 12'h000), C_STR, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_dwdata !== e.dwdata) $display("FAIL sub_result: got %h expected %h", o_dwdata, e.dwdata); else n_pass++;
  endtask

  task automatic test_branch();
    exp_t e;
    exp_q.push_back('{4, 13'h9, 1'b0, 32'h0, 32'h0});
    exp_q.push_back('{4, 13'h100, 1'b1, 32'h40, 32'h0});
    exp_q.push_back('{4, 13'h101, 1'b0, 32'h0, 32'h0});
    exp_q.push_back('{4, 13'h1FFF, 1'b0, 32'h0, 32'h0});
    exp_q.push_back('{4, 13'h0, 1'b1, 32'h40, 32'h9});
    exec_instr(mk(4'd0, 4'd6, 12'h100), C_BR, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL br_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (imem_addr !== 13'h100) $display("FAIL br_target: got %h expected 100", imem_addr); else n_pass++;
    exec_instr(mk(4'd2, 4'd6, 12'h000), C_STR, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL br_chk_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (o_dwdata !== e.dwdata) $display("FAIL br_no_rf_write: got %h expected %h", o_dwdata, e.dwdata); else n_pass++;
    exec_instr({8'hEA, 24'h001EFC}, C_BR15, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL br15_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (imem_addr !== 13'h1FFF) $display("FAIL br15_target: got %h expected 1fff", imem_addr); else n_pass++;
    exec_instr(mk(4'd0, 4'd5, 12'h009), C_MOV, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL wrap_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (imem_addr !== 13'h0) $display("FAIL wrap_pc: got %h expected 0", imem_addr); else n_pass++;
    exec_instr(mk(4'd2, 4'd5, 12'h000), C_STR, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL wrap_chk_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
    n_checks++; if (o_dwdata !== e.dwdata) $display("FAIL wrap_r5: got %h expected %h", o_dwdata, e.dwdata); else n_pass++;
  endtask

  task automatic test_reset_in_mem();
    exp_t e;
    logic got;
    apply_ctl(C_LDR);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      imem_ack   = imem_req;
      imem_rdata = mk(4'd2, 4'd7, 12'h010);
      dmem_ack   = 1'b0;
      if (dmem_req) got = 1'b1;
      else @(negedge clk);
    end
    imem_ack = 1'b0;
    n_checks++; if (got !== 1'b1) $display("FAIL rim_reach_mem: got %b expected 1", got); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL rim_dreq_drop: got %b expected 0", dmem_req); else n_pass++;
    n_checks++; if (imem_addr !== 13'h0) $display("FAIL rim_pc: got %h expected 0", imem_addr); else n_pass++;
    n_checks++; if (instr !== 32'h0) $display("FAIL rim_ir: got %h expected 0", instr); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1) $display("FAIL rim_refetch: got %b expected 1", imem_req); else n_pass++;
    exp_q.push_back('{4, 13'h0, 1'b0, 32'h0, 32'h0});
    exec_instr(mk(4'd0, 4'd7, 12'h003), C_MOV, 0, 0, 32'h0);
    e = exp_q.pop_front();
    n_checks++; if (o_cyc !== e.cycles) $display("FAIL rim_cycles: got %0d expected %0d", o_cyc, e.cycles); else n_pass++;
    n_checks++; if (o_faddr !== e.faddr) $display("FAIL rim_faddr: got %h expected %h", o_faddr, e.faddr); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    apply_ctl(C_MOV);
    test_reset();
    test_mov();
    test_fetch_wait();
    test_load();
    test_store();
    test_cond_fail();
    test_flags();
    test_branch();
    test_reset_in_mem();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
